// File: rtl/decrypt_key_sched.sv
// AES-128 round-key expander and reverse (rk10..rk0) streamer for the inverse-cipher rounds.
// Latency: accept to keys_done is 10 cycles; rk_start/rk_next to rk_out is 1 cycle; no backpressure: key_ready=0 while expanding.
module aes_sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the forward affine transform.
  always_comb begin
    logic [7:0] t;
    logic [7:0] r;
    t = addr;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    data = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  end

endmodule

module decrypt_key_sched #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [127:0]     key_in,
  output logic             key_ready,
  output logic             keys_done,
  input  logic             rk_start,
  input  logic             rk_next,
  output logic             rk_valid,
  output logic [127:0]     rk_out,
  output logic [IDX_W-1:0] rk_idx,
  output logic             rk_last
);

  typedef enum logic [1:0] {IDLE, EXPAND, LOADED} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  state_t           state, state_nxt;
  logic [127:0]     rk_mem [0:NR];
  logic [127:0]     cur_key;
  logic [127:0]     nxt_key;
  logic [7:0]       rcon;
  logic [IDX_W-1:0] cnt;
  logic             accept;
  logic [31:0]      rot_w, sub_w, t_w;
  logic [31:0]      w0, w1, w2, w3;

  assign accept = key_valid && key_ready;

  // cur_key always mirrors rk[cnt-1], so the next key never needs a memory read.
  assign rot_w = {cur_key[23:0], cur_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .addr(rot_w[8*g +: 8]),
      .data(sub_w[8*g +: 8])
    );
  end

  assign t_w     = sub_w ^ {rcon, 24'h000000};
  assign w0      = cur_key[127:96] ^ t_w;
  assign w1      = cur_key[95:64]  ^ w0;
  assign w2      = cur_key[63:32]  ^ w1;
  assign w3      = cur_key[31:0]   ^ w2;
  assign nxt_key = {w0, w1, w2, w3};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_ready = (state != EXPAND);
    keys_done = (state == LOADED);
    case (state)
      IDLE, LOADED: if (key_valid) state_nxt = EXPAND;
      EXPAND:       if (cnt == LAST_IDX) state_nxt = LOADED;
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rk_mem[0] <= key_in;
      cur_key   <= key_in;
      rcon      <= 8'h01;
      cnt       <= ONE;
    end else if (state == EXPAND) begin
      rk_mem[cnt] <= nxt_key;
      cur_key     <= nxt_key;
      rcon        <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      cnt         <= cnt + ONE;
    end
  end

  // A new key outranks any stream request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_valid <= 1'b0;
      rk_out   <= '0;
      rk_idx   <= '0;
    end else if (accept) begin
      rk_valid <= 1'b0;
    end else if (state == LOADED && rk_start) begin
      rk_valid <= 1'b1;
      rk_out   <= rk_mem[NR];
      rk_idx   <= LAST_IDX;
    end else if (rk_next && rk_valid) begin
      if (rk_idx != '0) begin
        rk_idx <= rk_idx - ONE;
        rk_out <= rk_mem[rk_idx - ONE];
      end else begin
        rk_valid <= 1'b0;
      end
    end
  end

  assign rk_last = rk_valid && (rk_idx == '0);

endmodule

// File: tb/tb_decrypt_key_sched.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares after each edge.
module tb_decrypt_key_sched;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic [127:0] key_in = '0;
  logic         rk_start = 1'b0;
  logic         rk_next = 1'b0;
  logic         key_ready, keys_done, rk_valid, rk_last;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;

  decrypt_key_sched #(.NR(NR), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in),
    .key_ready(key_ready), .keys_done(keys_done), .rk_start(rk_start), .rk_next(rk_next),
    .rk_valid(rk_valid), .rk_out(rk_out), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         key_ready;
    logic         keys_done;
    logic         rk_valid;
    logic         rk_last;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         has_gold;
    logic [127:0] gold;
  } exp_t;

  exp_t  sb[$];
  string nq[$];
  int    checks = 0;
  int    failures = 0;

  logic [7:0] sbox_tab [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] rcon_tab [0:9] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  // Behavioural model: phase counters plus a pointer into a precomputed key table.
  int           m_busy = 0;
  bit           m_loaded = 1'b0;
  bit           m_valid = 1'b0;
  int           m_idx = 0;
  logic [127:0] m_out = '0;
  logic [127:0] m_keys [0:10];

  task automatic ref_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rcon_tab[i/4-1], 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step(input bit rs, input bit kv, input logic [127:0] k, input bit st,
                      input bit nx, input string nm, input bit hg = 1'b0,
                      input logic [127:0] g = '0);
    exp_t e;
    bit   was_loaded;
    rst = rs; key_valid = kv; key_in = k; rk_start = st; rk_next = nx;
    was_loaded = m_loaded;
    if (rs) begin
      m_busy = 0; m_loaded = 1'b0; m_valid = 1'b0; m_idx = 0; m_out = '0;
    end else if (kv && m_busy == 0) begin
      ref_expand(k);
      m_busy = NR; m_loaded = 1'b0; m_valid = 1'b0;
    end else begin
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_loaded = 1'b1;
      end
      if (was_loaded && st) begin
        m_idx = NR; m_out = m_keys[NR]; m_valid = 1'b1;
      end else if (nx && m_valid) begin
        if (m_idx > 0) begin
          m_idx--;
          m_out = m_keys[m_idx];
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    e.key_ready = (m_busy == 0);
    e.keys_done = m_loaded;
    e.rk_valid  = m_valid;
    e.rk_last   = m_valid && (m_idx == 0);
    e.rk_idx    = 4'(m_idx);
    e.rk_out    = m_out;
    e.has_gold  = hg;
    e.gold      = g;
    sb.push_back(e);
    nq.push_back(nm);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t  e;
    string nm;
    #1;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      nm = nq.pop_front();
      checks++;
      if ({key_ready, keys_done, rk_valid, rk_last, rk_idx, rk_out} !==
          {e.key_ready, e.keys_done, e.rk_valid, e.rk_last, e.rk_idx, e.rk_out}) begin
        failures++;
        $display("FAIL %s: got rdy=%b done=%b vld=%b last=%b idx=%0d out=%h, want rdy=%b done=%b vld=%b last=%b idx=%0d out=%h",
                 nm, key_ready, keys_done, rk_valid, rk_last, rk_idx, rk_out,
                 e.key_ready, e.keys_done, e.rk_valid, e.rk_last, e.rk_idx, e.rk_out);
      end
      if (e.has_gold) begin
        checks++;
        if (rk_out !== e.gold) begin
          failures++;
          $display("FAIL %s_vector: got rk_out=%h, want %h", nm, rk_out, e.gold);
        end
      end
    end
  end

  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K1_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K3    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  initial begin
    @(negedge clk);
    step(1, 0, '0, 0, 0, "reset");
    step(1, 1, K1, 1, 1, "reset_held");
    step(0, 0, '0, 1, 1, "start_in_idle");

    step(0, 1, K1, 0, 0, "t1_accept");
    for (int i = 0; i < NR; i++) step(0, 0, '0, (i == 3), 0, "t1_expand");
    step(0, 0, '0, 1, 0, "t1_rk10", 1'b1, K1_10);
    for (int i = NR - 1; i >= 0; i--)
      step(0, 0, '0, 0, 1, "t2_next", (i <= 1), (i == 1) ? K1_1 : K1);
    step(0, 0, '0, 0, 1, "t2_past_end");
    step(0, 0, '0, 0, 1, "t2_next_invalid");
    step(0, 0, '0, 1, 0, "t2_replay", 1'b1, K1_10);

    step(0, 1, K3, 0, 0, "t3_accept");
    for (int i = 0; i < NR; i++) step(0, 0, '0, 0, 0, "t3_expand");
    step(0, 0, '0, 1, 0, "t3_rk10", 1'b1, K3_10);

    for (int i = 0; i < 6; i++) step(0, 0, '0, 0, 1, "t4_next");
    step(0, 0, '0, 1, 0, "t4_restart", 1'b1, K3_10);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 1, "t4_next2");
    step(0, 0, '0, 1, 1, "t4_start_and_next", 1'b1, K3_10);

    step(0, 1, rand128(), 0, 0, "t5_accept");
    for (int i = 0; i < NR; i++) step(0, 1, rand128(), 1, 0, "t5_expand_kv");
    step(0, 0, '0, 1, 0, "t5_rk10");
    step(0, 1, rand128(), 1, 1, "t5_key_wins");
    for (int i = 0; i < NR; i++) step(0, 0, '0, 0, 0, "t5_expand2");
    step(0, 0, '0, 1, 0, "t5_new_rk10");

    step(0, 1, rand128(), 0, 0, "t6_accept");
    for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 0, "t6_expand");
    step(1, 0, '0, 0, 0, "t6_rst");
    step(0, 0, '0, 0, 1, "t6_next_invalid");
    step(0, 1, rand128(), 0, 0, "t6_fresh");
    for (int i = 0; i < NR; i++) step(0, 0, '0, 0, 0, "t6_expand2");
    step(0, 0, '0, 1, 0, "t6_rk10");
    for (int i = 0; i < 12; i++) step(0, 0, '0, 0, 1, "t6_stream");

    for (int n = 0; n < 600; n++)
      step(($urandom % 250) == 0, ($urandom % 30) == 0, rand128(),
           ($urandom % 10) == 0, ($urandom % 3) != 0, "random");

    step(0, 0, '0, 0, 0, "drain");
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
